// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer and its return-address stack.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_RET,
        SEL_CALL,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_SEQ
    } pc_sel_e;

    // Bits needed to count 0..depth inclusive.
    function automatic int unsigned ras_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Link between the next-PC decode (master) and the return-address stack (slave).
interface pc_sequencer_if #(
    parameter int unsigned PC_WIDTH = 6,
    parameter int unsigned CNT_W    = 3
);
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] push_data;
    logic [PC_WIDTH-1:0] top_data;
    logic [CNT_W-1:0]    depth;
    logic                empty;
    logic                full;
    logic                overflow;
    logic                underflow;

    modport master (
        output push, pop, push_data,
        input  top_data, depth, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data,
        output top_data, depth, empty, full, overflow, underflow
    );
endinterface

// File: rtl/pc_return_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module pc_return_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 6,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  ras
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = ras_cnt_width(RAS_DEPTH);

    logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                is_full;
    logic                is_empty;

    assign is_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign is_empty = (cnt_q == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (ras.push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (is_full) ovf_d = 1'b1;
            else         cnt_d = cnt_q + CNT_W'(1);
        end else if (ras.pop) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q - PTR_W'(1);
                cnt_d    = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Entry storage is never visible beyond the depth count, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!reset && ras.push) mem_q[wr_ptr_q] <= ras.push_data;
    end

    assign ras.top_data  = mem_q[wr_ptr_q - PTR_W'(1)];
    assign ras.depth     = cnt_q;
    assign ras.empty     = is_empty;
    assign ras.full      = is_full;
    assign ras.overflow  = ovf_q;
    assign ras.underflow = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with fixed-priority next-PC select and a return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = 6,
    parameter int unsigned OFFSET_WIDTH = 32,
    parameter int unsigned PC_STEP      = 4,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    input  logic                    jump,
    input  logic [PC_WIDTH-1:0]     jump_target,
    input  logic                    call,
    input  logic                    ret,
    output logic [PC_WIDTH-1:0]     pc,
    output logic [PC_WIDTH-1:0]     pc_plus,
    output logic                    ras_empty,
    output logic                    ras_full,
    output logic                    ras_overflow,
    output logic                    ras_underflow
);

    localparam int unsigned CNT_W = ras_cnt_width(RAS_DEPTH);

    pc_sequencer_if #(.PC_WIDTH(PC_WIDTH), .CNT_W(CNT_W)) ras_if ();

    pc_return_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .ras   (ras_if.slave)
    );

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_plus_c;
    logic [PC_WIDTH-1:0] branch_tgt_c;
    pc_sel_e             sel_c;

    assign pc_plus_c    = pc_q + PC_WIDTH'(PC_STEP);
    assign branch_tgt_c = pc_plus_c + branch_offset[PC_WIDTH-1:0];

    // Upper offset bits are ignored by design; the branch wraps within PC_WIDTH.
    generate
        if (OFFSET_WIDTH > PC_WIDTH) begin : g_off_hi
            logic unused_off_hi;
            assign unused_off_hi = ^branch_offset[OFFSET_WIDTH-1:PC_WIDTH];
        end
    endgenerate

    logic unused_depth;
    assign unused_depth = ^ras_if.depth;

    always_comb begin
        sel_c = SEL_SEQ;
        if      (stall)  sel_c = SEL_HOLD;
        else if (ret)    sel_c = SEL_RET;
        else if (call)   sel_c = SEL_CALL;
        else if (jump)   sel_c = SEL_JUMP;
        else if (branch) sel_c = SEL_BRANCH;
    end

    always_comb begin
        pc_d = pc_plus_c;
        unique case (sel_c)
            SEL_HOLD:   pc_d = pc_q;
            SEL_RET:    pc_d = ras_if.empty ? pc_plus_c : ras_if.top_data;
            SEL_CALL:   pc_d = jump_target;
            SEL_JUMP:   pc_d = jump_target;
            SEL_BRANCH: pc_d = branch_tgt_c;
            default:    pc_d = pc_plus_c;
        endcase
    end

    assign ras_if.push      = (sel_c == SEL_CALL);
    assign ras_if.pop       = (sel_c == SEL_RET);
    assign ras_if.push_data = pc_plus_c;

    always_ff @(posedge clk) begin
        if (reset) pc_q <= PC_WIDTH'(RESET_VECTOR);
        else       pc_q <= pc_d;
    end

    assign pc            = pc_q;
    assign pc_plus       = pc_plus_c;
    assign ras_empty     = ras_if.empty;
    assign ras_full      = ras_if.full;
    assign ras_overflow  = ras_if.overflow;
    assign ras_underflow = ras_if.underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch;
    logic [31:0] branch_offset;
    logic        jump;
    logic [5:0]  jump_target;
    logic        call;
    logic        ret;
    logic [5:0]  pc;
    logic [5:0]  pc_plus;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_cmp = 0;
    int n_err = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic rs, input logic st, input logic br, input logic [31:0] off,
                        input logic jp, input logic [5:0] tgt, input logic cl, input logic rt);
        reset = rs; stall = st; branch = br; branch_offset = off;
        jump = jp; jump_target = tgt; call = cl; ret = rt;
        @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0; branch = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_target = '0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic check_flags(input string tag, input logic e, input logic f,
                               input logic o, input logic u);
        check_eq({tag, "_empty"}, 32'(ras_empty), 32'(e));
        check_eq({tag, "_full"},  32'(ras_full),  32'(f));
        check_eq({tag, "_ovf"},   32'(ras_overflow),  32'(o));
        check_eq({tag, "_unf"},   32'(ras_underflow), 32'(u));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_target = '0; call = 1'b0; ret = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_pc", 32'(pc), 32'd0);
        check_eq("rst_pc_plus", 32'(pc_plus), 32'd4);
        check_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);

        // Sequential run and wrap
        for (int i = 1; i <= 16; i++) begin
            idle();
            check_eq($sformatf("seq_pc%0d", i), 32'(pc), 32'((i * 4) % 64));
        end
        check_flags("seq", 1'b1, 1'b0, 1'b0, 1'b0);

        // Branch forward from pc=4
        do_reset();
        idle();
        check_eq("br_pre", 32'(pc), 32'd4);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0007, 1'b0, 6'd0, 1'b0, 1'b0);
        check_eq("br_fwd", 32'(pc), 32'd15);

        // Branch with negative offset from pc=28 wraps in 6 bits
        do_reset();
        for (int i = 0; i < 7; i++) idle();
        check_eq("brn_pre", 32'(pc), 32'd28);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 6'd0, 1'b0, 1'b0);
        check_eq("br_neg", 32'(pc), 32'd31);

        // Plain jump leaves stack untouched
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 6'd33, 1'b0, 1'b0);
        check_eq("jump_pc", 32'(pc), 32'd33);
        check_eq("jump_empty", 32'(ras_empty), 32'd1);

        // Call then return
        do_reset();
        idle(); idle();
        check_eq("call_pre", 32'(pc), 32'd8);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd40, 1'b1, 1'b0);
        check_eq("call_pc", 32'(pc), 32'd40);
        check_eq("call_empty", 32'(ras_empty), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1);
        check_eq("ret_pc", 32'(pc), 32'd12);
        check_eq("ret_empty", 32'(ras_empty), 32'd1);

        // Five nested calls overflow a four-entry stack
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'((i + 1) * 4), 1'b1, 1'b0);
            check_eq($sformatf("nest_pc%0d", i), 32'(pc), 32'((i + 1) * 4));
        end
        check_flags("nest", 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1);
            check_eq($sformatf("unwind_pc%0d", i), 32'(pc), 32'(20 - i * 4));
        end
        check_eq("unwind_empty", 32'(ras_empty), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1);
        check_eq("ret_empty_pc", 32'(pc), 32'd12);
        check_flags("unf", 1'b1, 1'b0, 1'b1, 1'b1);

        // Stall holds pc and sticky flags
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'd9, 1'b1, 1'b1);
        check_eq("stall_pc", 32'(pc), 32'd12);
        check_flags("stall", 1'b1, 1'b0, 1'b1, 1'b1);

        // Reset during a call discards the call and clears flags
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd40, 1'b1, 1'b0);
        check_eq("rstcall_pc", 32'(pc), 32'd0);
        check_flags("rstcall", 1'b1, 1'b0, 1'b0, 1'b0);

        // Call beats jump and branch
        step(1'b0, 1'b0, 1'b1, 32'h0000_0007, 1'b1, 6'd48, 1'b1, 1'b0);
        check_eq("prio_pc", 32'(pc), 32'd48);
        check_eq("prio_empty", 32'(ras_empty), 32'd0);
        check_eq("prio_full", 32'(ras_full), 32'd0);

        // Same request under stall does nothing
        do_reset();
        step(1'b0, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 6'd48, 1'b1, 1'b0);
        check_eq("prio_stall_pc", 32'(pc), 32'd0);
        check_eq("prio_stall_empty", 32'(ras_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 6, meaning program counter width in bits.
REQ-002 SHALL have parameter OFFSET_WIDTH, default 32, meaning width of the pre-shifted signed branch offset.
REQ-003 SHALL have parameter PC_STEP, default 4, meaning sequential increment in address units.
REQ-004 SHALL have parameter RESET_VECTOR, default 0, meaning PC value loaded on reset.
REQ-005 SHALL have parameter RAS_DEPTH, default 4 (power of two, 2..16), meaning return-address stack entries.
REQ-006 SHALL have the following ports; one clock; reset is synchronous and active-high:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous, active-high reset
  stall  in  1  hold PC and stack this cycle
  branch  in  1  take PC-relative branch
  branch_offset  in  OFFSET_WIDTH  signed offset, already shifted
  jump  in  1  absolute jump
  jump_target  in  PC_WIDTH  absolute target for jump/call
  call  in  1  push return address, go to jump_target
  ret  in  1  pop return address into PC
  pc  out  PC_WIDTH  current program counter (registered)
  pc_plus  out  PC_WIDTH  pc + PC_STEP (combinational)
  ras_empty  out  1  stack holds no entries
  ras_full  out  1  stack holds RAS_DEPTH entries
  ras_overflow  out  1  sticky: a push discarded an entry
  ras_underflow  out  1  sticky: ret issued with empty stack

Function
REQ-007 pc_plus SHALL equal (pc + PC_STEP) mod 2^PC_WIDTH.
REQ-008 Branch target SHALL be (pc_plus + branch_offset[PC_WIDTH-1:0]) mod 2^PC_WIDTH; upper offset bits ignored, wrap-around silent.
REQ-009 Next-PC selection SHALL use fixed priority: stall > ret > call > jump > branch > sequential; lower-priority requests in the same cycle are dropped.
REQ-010 stall SHALL hold pc and all stack state and flags unchanged.
REQ-011 Sequential: pc <= pc_plus; wrap from 2^PC_WIDTH-PC_STEP to 0 with no flag.
REQ-012 jump: pc <= jump_target; stack unchanged.
REQ-013 call: push pc_plus, pc <= jump_target, same edge.
REQ-014 call when full: oldest entry discarded (circular), new entry pushed, depth stays RAS_DEPTH, ras_overflow set.
REQ-015 ret when non-empty: pc <= top entry, depth decrements.
REQ-016 ret when empty: pc <= pc_plus, ras_underflow set, depth stays 0.
REQ-017 PC update latency SHALL be one clock: pc reflects request sampled on prior rising edge.
REQ-018 ras_empty/ras_full SHALL be decoded from registered depth count, valid same cycle as pc.
REQ-019 Overflow/underflow flags SHALL clear only on reset.

Reset
REQ-020 On reset at a rising edge: pc = RESET_VECTOR, depth = 0, ras_empty = 1, ras_full = 0, both flags = 0.
REQ-021 reset SHALL override stall and all requests; reset mid-call/ret discards that operation.
REQ-022 Stack entry storage SHALL need no reset; entries beyond depth are never observable.

Structure
REQ-023 Shared package pc_seq_pkg SHALL hold the next-PC select enum (SEL_HOLD, SEL_RET, SEL_CALL, SEL_JUMP, SEL_BRANCH, SEL_SEQ) and the RAS depth-count width function.
REQ-024 Stack SHALL be a separate sub-module pc_return_stack (push, pop, data, depth, empty, full, overflow, underflow); priority decode and PC register live in pc_sequencer.

Verification (PC_WIDTH=6, PC_STEP=4, RESET_VECTOR=0, RAS_DEPTH=4)
REQ-025 Reset, then 16 idle cycles -> pc 0,4,...,60, then 0 (wrap), no flags.
REQ-026 pc=4, branch=1, offset=32'h0000_0007 -> next pc = 8+7 = 15; pc=28, branch=1, offset=32'hFFFF_FFFF -> pc=31 (wrap via low 6 bits).
REQ-027 pc=8, call, jump_target=40 -> pc=40, depth 1; next cycle ret -> pc=12, ras_empty=1.
REQ-028 Five calls from pc 0,4,8,12,16 (target = pc+4) -> ras_full=1, ras_overflow=1; four rets return 20,16,12,8; fifth ret -> pc_plus, ras_underflow=1.
REQ-029 branch+jump+call together at pc=0, jump_target=48 -> call wins: pc=48, depth 1; same with stall=1 -> pc=0 held, depth 0.
REQ-030 Reset asserted during a call cycle -> pc=0, depth 0, flags 0 on that edge.
